// File: rtl/rng_stream_if.sv
// Request/response bundle for rng_stream: seeding and control in, random word and status out.
interface rng_stream_if #(
  parameter int LFSR_W    = 16,
  parameter int OUT_BYTES = 2
);
  logic                   seed_load;
  logic [LFSR_W-1:0]      seed;
  logic [1:0]             mode;
  logic                   start;
  logic                   continuous;
  logic                   out_ready;
  logic                   out_valid;
  logic [8*OUT_BYTES-1:0] rand_out;
  logic                   busy;
  logic                   seed_fixed;

  modport master (
    output seed_load, seed, mode, start, continuous, out_ready,
    input  out_valid, rand_out, busy, seed_fixed
  );

  modport slave (
    input  seed_load, seed, mode, start, continuous, out_ready,
    output out_valid, rand_out, busy, seed_fixed
  );
endinterface

// File: rtl/rng_stream.sv
// Random word generator: Fibonacci/Galois LFSR bits serialised into an N-bit word,
// optionally whitened per byte through the AES S-box, delivered on valid/ready.
module rng_stream #(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] FIB_TAPS  = 16'hB400,
  parameter logic [LFSR_W-1:0] GAL_TAPS  = 16'h002D,
  parameter int                OUT_BYTES = 2,
  parameter bit                WHITEN    = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  rng_stream_if.slave  bus
);

  localparam int N_BITS = 8 * OUT_BYTES;
  localparam int CNT_W  = $clog2(N_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BITS - 1);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[11'd2047 - {x, 3'b000} -: 8];
  endfunction

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LFSR_W-1:0]  r_fib;
  logic [LFSR_W-1:0]  r_gal;
  logic [CNT_W-1:0]   r_cnt;
  // The SIPO MSB would fall off before ever reaching word_reg, so only N-1 bits are kept.
  logic [N_BITS-2:0]  r_sipo;
  logic [N_BITS-1:0]  r_word;
  logic [1:0]         r_mode;
  logic               r_seed_fixed;

  logic               w_fib_fb;
  logic [LFSR_W-1:0]  w_fib_nxt;
  logic               w_gal_fb;
  logic [LFSR_W-1:0]  w_gal_nxt;
  logic               w_bit;
  logic               w_last;
  logic               w_seed_zero;
  logic [LFSR_W-1:0]  w_seed_eff;
  logic [N_BITS-1:0]  w_rand;

  assign w_fib_fb    = ^(r_fib & FIB_TAPS);
  assign w_fib_nxt   = {r_fib[LFSR_W-2:0], w_fib_fb};
  assign w_gal_fb    = r_gal[LFSR_W-1];
  assign w_gal_nxt   = {r_gal[LFSR_W-2:0], 1'b0} ^ (w_gal_fb ? GAL_TAPS : '0);
  assign w_last      = (r_cnt == CNT_LAST);
  assign w_seed_zero = (bus.seed == '0);
  assign w_seed_eff  = w_seed_zero ? LFSR_W'(1) : bus.seed;

  always_comb begin
    w_bit = w_fib_fb ^ w_gal_fb;
    case (r_mode)
      2'd0:    w_bit = w_fib_fb;
      2'd1:    w_bit = w_gal_fb;
      default: w_bit = w_fib_fb ^ w_gal_fb;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.seed_load) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (bus.start) w_state_nxt = S_SHIFT;
        S_SHIFT: if (w_last) w_state_nxt = S_OUT;
        S_OUT:   if (bus.out_ready) w_state_nxt = bus.continuous ? S_SHIFT : S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fib        <= LFSR_W'(1);
      r_gal        <= LFSR_W'(1);
      r_cnt        <= '0;
      r_sipo       <= '0;
      r_word       <= '0;
      r_mode       <= 2'd0;
      r_seed_fixed <= 1'b0;
    end else if (bus.seed_load) begin
      r_fib        <= w_seed_eff;
      r_gal        <= w_seed_eff;
      r_cnt        <= '0;
      r_seed_fixed <= w_seed_zero;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mode <= bus.mode;
            r_cnt  <= '0;
          end
        end
        S_SHIFT: begin
          r_fib  <= w_fib_nxt;
          r_gal  <= w_gal_nxt;
          r_sipo <= {r_sipo[N_BITS-3:0], w_bit};
          if (w_last) begin
            r_word <= {r_sipo, w_bit};
            r_cnt  <= '0;
          end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
          end
        end
        S_OUT: begin
          if (bus.out_ready) r_cnt <= '0;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  always_comb begin
    w_rand = '0;
    for (int i = 0; i < OUT_BYTES; i++) begin
      w_rand[8*i +: 8] = WHITEN ? sbox(r_word[8*i +: 8]) : r_word[8*i +: 8];
    end
  end

  assign bus.rand_out   = w_rand;
  assign bus.out_valid  = (r_state == S_OUT);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.seed_fixed = r_seed_fixed;

endmodule
